// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-entry valid/ready execute stage around a RISC-V style ALU
module alu_riscv (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  op,
  output logic [31:0] result,
  output logic        flag
);
  logic lt, ltu, base;
  assign lt = $signed(a) < $signed(b);
  assign ltu = a < b;
  assign base = op[2] ? (op[1] ? ltu : lt) : (a == b);
  assign flag = op[0] ? !base : base;
  always_comb begin
    result = '0;
    case (op)
      5'b00000: result = a + b;
      5'b01000: result = a - b;
      5'b00001: result = a << b[4:0];
      5'b00010: result = {31'd0, lt};
      5'b00011: result = {31'd0, ltu};
      5'b00100: result = a ^ b;
      5'b00101: result = a >> b[4:0];
      5'b01101: result = $signed(a) >>> b[4:0];
      5'b00110: result = a | b;
      5'b00111: result = a & b;
      default:  result = '0;
    endcase
  end
endmodule

module alu_exec_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [4:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_flag,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      retired_cnt
);
  logic             s1_valid, s2_valid, s1_adv, in_fire, branch, legal, alu_flag;
  logic [31:0]      s1_a, s1_b, alu_result;
  logic [4:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  alu_riscv u_alu (.a(s1_a), .b(s1_b), .op(s1_op), .result(alu_result), .flag(alu_flag));
  assign s1_adv = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign in_fire = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign branch = s1_op[4:3] == 2'b11;
  // 10xxx and 1101x are holes in the branch space; 01xxx only has SUB and SRA
  assign legal = s1_op[4:3] == 2'b00 || s1_op == 5'b01000 || s1_op == 5'b01101 ||
                 (branch && s1_op[2:1] != 2'b01);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_op <= '0;
      s1_tag <= '0;
      out_result <= '0;
      out_flag <= 1'b0;
      out_illegal <= 1'b0;
      out_tag <= '0;
      retired_cnt <= '0;
    end else begin
      s1_valid <= !flush && (in_fire || (s1_valid && !s1_adv));
      s2_valid <= !flush && (s1_adv || (s2_valid && !out_ready));
      if (in_fire) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_op <= in_op;
        s1_tag <= in_tag;
      end
      if (s1_adv && !flush) begin
        out_result <= (legal && !branch) ? alu_result : '0;
        out_flag <= legal && branch && alu_flag;
        out_illegal <= !legal;
        out_tag <= s1_tag;
      end
      if (out_valid && out_ready) retired_cnt <= retired_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed table, corner sequences and random traffic against a scoreboard model
module tb_alu_exec_stage;
  localparam int TAG_W = 5;
  typedef struct {
    logic [31:0]      a, b;
    logic [4:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             flag, ill;
  } vec_t;

  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, in_ready;
  logic [31:0] in_a = 0, in_b = 0;
  logic [4:0] in_op = 0;
  logic [TAG_W-1:0] in_tag = 0;
  logic out_valid, out_ready, out_flag, out_illegal;
  logic [31:0] out_result, retired_cnt;
  logic [TAG_W-1:0] out_tag;
  logic ready_cmd = 1, rand_bp = 0, rnd_ready = 1;
  assign out_ready = rand_bp ? rnd_ready : ready_cmd;

  alu_exec_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flag(out_flag),
    .out_illegal(out_illegal), .out_tag(out_tag), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 rnd_ready = $urandom_range(3) != 0;
  end

  int n_pass = 0, n_total = 0, exp_cnt = 0;
  vec_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, input logic [4:0] op,
                              input logic [TAG_W-1:0] tag, input logic [31:0] res,
                              input logic flag, ill);
    vec_t v;
    v = '{a:a, b:b, op:op, tag:tag, res:res, flag:flag, ill:ill};
    return v;
  endfunction

  // Reference: the architectural meaning of each opcode in plain integer arithmetic
  function automatic vec_t model(input logic [31:0] a, b, input logic [4:0] op,
                                 input logic [TAG_W-1:0] tag);
    int sa, sb;
    vec_t v;
    sa = a;
    sb = b;
    v = mk(a, b, op, tag, 0, 0, 0);
    case (op)
      5'b00000: v.res = a + b;
      5'b01000: v.res = a - b;
      5'b00001: v.res = a << b[4:0];
      5'b00010: v.res = (sa < sb) ? 1 : 0;
      5'b00011: v.res = (a < b) ? 1 : 0;
      5'b00100: v.res = a ^ b;
      5'b00101: v.res = a >> b[4:0];
      5'b01101: v.res = sa >>> b[4:0];
      5'b00110: v.res = a | b;
      5'b00111: v.res = a & b;
      5'b11000: v.flag = a == b;
      5'b11001: v.flag = a != b;
      5'b11100: v.flag = sa < sb;
      5'b11101: v.flag = sa >= sb;
      5'b11110: v.flag = a < b;
      5'b11111: v.flag = a >= b;
      default:  v.ill = 1;
    endcase
    return v;
  endfunction

  logic stalled = 0;
  logic [39:0] held;
  always @(negedge clk) begin
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) check("hold", {out_valid, out_result, out_flag, out_illegal, out_tag}, held);
      if (out_valid && out_ready) begin
        check("retired_cnt", retired_cnt, exp_cnt);
        exp_cnt++;
        check("exp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          vec_t e;
          e = exp_q.pop_front();
          check("out_result", out_result, e.res);
          check("out_flag", out_flag, e.flag);
          check("out_illegal", out_illegal, e.ill);
          check("out_tag", out_tag, e.tag);
        end
      end
      stalled = out_valid && !out_ready && !flush;
      held = {out_valid, out_result, out_flag, out_illegal, out_tag};
    end
  end

  task automatic send(input vec_t v, output int waits);
    bit done;
    done = 0;
    waits = 0;
    in_valid = 1;
    in_a = v.a;
    in_b = v.b;
    in_op = v.op;
    in_tag = v.tag;
    while (!done && waits <= 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(v);
        done = 1;
      end else waits++;
    end
    check("accepted", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1 check("drain_cnt", retired_cnt, exp_cnt);
  endtask

  vec_t tbl[13];
  initial begin
    int w, tw, base;
    logic [31:0] corner[4];
    logic [31:0] ra, rb;
    corner[0] = 0; corner[1] = 1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
    tbl[0]  = mk(20, 10, 5'b01000, 1, 10, 0, 0);
    tbl[1]  = mk(32'hFFFF_FFFF, 1, 5'b00010, 2, 1, 0, 0);
    tbl[2]  = mk(32'hFFFF_FFFF, 1, 5'b00011, 3, 0, 0, 0);
    tbl[3]  = mk(32'h8000_0000, 4, 5'b01101, 4, 32'hF800_0000, 0, 0);
    tbl[4]  = mk(7, 33, 5'b00001, 5, 14, 0, 0);
    tbl[5]  = mk(32'hFFFF_FFFF, 1, 5'b11100, 6, 0, 1, 0);
    tbl[6]  = mk(7, 1, 5'b11101, 7, 0, 1, 0);
    tbl[7]  = mk(1, 32'hFFFF_FFFF, 5'b11111, 8, 0, 0, 0);
    tbl[8]  = mk(7, 1, 5'b11001, 9, 0, 1, 0);
    tbl[9]  = mk(7, 7, 5'b11000, 10, 0, 1, 0);
    tbl[10] = mk(5, 5, 5'b01001, 11, 0, 0, 1);
    tbl[11] = mk(32'h8000_0000, 4, 5'b00101, 12, 32'h0800_0000, 0, 0);
    tbl[12] = mk(32'hFFFF_FFFF, 1, 5'b00000, 13, 0, 0, 0);

    #1 rst_n = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_flag", out_flag, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_tag", out_tag, 0);
    check("rst_cnt", retired_cnt, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    send(mk(10, 20, 5'b00000, 3, 30, 0, 0), w);
    in_valid = 0;
    @(negedge clk) check("lat_n1_valid", out_valid, 0);
    @(negedge clk) check("lat_n2_valid", out_valid, 1);
    check("lat_result", out_result, 30);
    check("lat_tag", out_tag, 3);
    @(posedge clk);
    #1 check("single_cnt", retired_cnt, 1);

    tw = 0;
    for (int i = 0; i < 13; i++) begin
      send(tbl[i], w);
      tw += w;
    end
    in_valid = 0;
    check("stream_stalls", tw, 0);
    drain();

    ready_cmd = 0;
    send(mk(7, 1, 5'b00100, 20, 6, 0, 0), w);
    send(mk(7, 1, 5'b00110, 21, 7, 0, 0), w);
    in_op = 5'b00111;
    in_tag = 22;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", out_result, 6);
    end
    @(posedge clk);
    #1 ready_cmd = 1;
    send(mk(7, 1, 5'b00111, 22, 1, 0, 0), w);
    check("bp_release_wait", w, 0);
    drain();

    ready_cmd = 0;
    send(mk(1, 2, 5'b00000, 1, 3, 0, 0), w);
    send(mk(3, 4, 5'b00000, 2, 7, 0, 0), w);
    in_valid = 0;
    base = exp_cnt;
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    exp_q.delete();
    ready_cmd = 1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_cnt", retired_cnt, base);
    repeat (3) @(negedge clk);

    @(posedge clk);
    #1;
    send(mk(5, 6, 5'b00000, 3, 11, 0, 0), w);
    send(mk(7, 8, 5'b00000, 4, 15, 0, 0), w);
    in_a = 9;
    in_tag = 5;
    flush = 1;
    @(negedge clk) check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    exp_q.delete();
    @(negedge clk);
    check("flush2_out_valid", out_valid, 0);
    check("flush2_cnt", retired_cnt, exp_cnt);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;

    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 0;
      if ($urandom_range(2) == 0) repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
      ra = $urandom_range(3) == 0 ? corner[$urandom_range(3)] : $urandom;
      rb = $urandom_range(3) == 0 ? corner[$urandom_range(3)] : $urandom;
      if ($urandom_range(7) == 0) rb = ra;
      send(model(ra, rb, 5'($urandom_range(31)), TAG_W'($urandom_range(31))), w);
    end
    rand_bp = 0;
    ready_cmd = 1;
    drain();

    send(mk(1, 1, 5'b00000, 6, 2, 0, 0), w);
    send(mk(2, 2, 5'b00000, 7, 4, 0, 0), w);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cnt", retired_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    send(mk(40, 2, 5'b00000, 8, 42, 0, 0), w);
    check("post_rst_wait", w, 0);
    drain();
    check("post_rst_cnt", retired_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
